// File: rtl/resp_recv_ingress_arbiter.sv
// Round-robin ingress arbiter for the response-receive path with per-lane credit limiting.
// Optional per-lane accepted-packet statistics are enabled by defining RESP_RECV_ARB_STATS_EN.
module resp_recv_ingress_arbiter #(
  parameter int unsigned N_CHAN          = 4,
  parameter int unsigned CHAN_LOG        = 2,
  parameter int unsigned META_WIDTH      = 256,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_WIDTH       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CHAN-1:0]              ingress_pkt_valid,
  input  logic [N_CHAN*META_WIDTH-1:0]   ingress_pkt_head,
  output logic [N_CHAN-1:0]              ingress_pkt_ready,
  output logic                           fetch_cxt_ingress_valid,
  output logic [META_WIDTH+CHAN_LOG-1:0] fetch_cxt_ingress_head,
  output logic [META_WIDTH-1:0]          fetch_cxt_ingress_data,
  output logic                           fetch_cxt_ingress_start,
  output logic                           fetch_cxt_ingress_last,
  input  logic                           fetch_cxt_ingress_ready,
  input  logic                           cxt_release_valid,
  input  logic [CHAN_LOG-1:0]            cxt_release_chan,
  output logic [N_CHAN*CNT_WIDTH-1:0]    chan_outstanding,
  output logic                           credit_underflow_err
`ifdef RESP_RECV_ARB_STATS_EN
  ,
  input  logic [CHAN_LOG-1:0]            stat_rd_chan,
  output logic [31:0]                    stat_pkt_count
`endif
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                         state_q, state_d;
  logic [CNT_WIDTH-1:0]           cnt_q [N_CHAN];
  logic [CHAN_LOG-1:0]            rr_ptr_q;
  logic [META_WIDTH+CHAN_LOG-1:0] head_q;
  logic                           err_q;

  logic [N_CHAN-1:0]     eligible;
  logic                  arb_en;
  logic                  grant_found;
  logic [CHAN_LOG-1:0]   grant_idx;
  logic                  accept;
  logic [META_WIDTH-1:0] meta_sel;
  logic [N_CHAN-1:0]     cnt_inc;
  logic [N_CHAN-1:0]     cnt_dec;
  logic                  rel_in_range;
  logic                  rel_cnt_zero;
  logic                  underflow;
  int unsigned           search_idx;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      eligible[i] = ingress_pkt_valid[i] && (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
    end
  end

  // Search starts one past the last granted lane so the previous winner goes last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = 0;
    for (int unsigned k = 1; k <= N_CHAN; k++) begin
      search_idx = (32'(rr_ptr_q) + k) % N_CHAN;
      if (!grant_found && eligible[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = CHAN_LOG'(search_idx);
      end
    end
  end

  always_comb begin
    meta_sel = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      if (grant_idx == CHAN_LOG'(i)) begin
        meta_sel = ingress_pkt_head[i*META_WIDTH +: META_WIDTH];
      end
    end
  end

  // A new header can be taken when idle or when the held request leaves this cycle.
  assign arb_en = (state_q == StIdle) || fetch_cxt_ingress_ready;
  assign accept = arb_en && grant_found && !rst;

  always_comb begin
    ingress_pkt_ready = '0;
    if (accept) begin
      ingress_pkt_ready = N_CHAN'(1) << grant_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (fetch_cxt_ingress_ready) begin
          state_d = accept ? StIssue : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rel_in_range = (32'(cxt_release_chan) < N_CHAN);
    rel_cnt_zero = 1'b0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      if (cxt_release_chan == CHAN_LOG'(i)) begin
        rel_cnt_zero = (cnt_q[i] == '0);
      end
    end
    underflow = cxt_release_valid && (!rel_in_range || rel_cnt_zero);
  end

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      cnt_inc[i] = accept && (grant_idx == CHAN_LOG'(i));
      cnt_dec[i] = cxt_release_valid && (cxt_release_chan == CHAN_LOG'(i)) && (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      head_q   <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_ptr_q <= grant_idx;
        head_q   <= {grant_idx, meta_sel};
      end
      if (underflow) begin
        err_q <= 1'b1;
      end
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        end else if (cnt_dec[i] && !cnt_inc[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    chan_outstanding = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      chan_outstanding[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

  assign fetch_cxt_ingress_valid = (state_q == StIssue);
  assign fetch_cxt_ingress_start = fetch_cxt_ingress_valid;
  assign fetch_cxt_ingress_last  = fetch_cxt_ingress_valid;
  assign fetch_cxt_ingress_head  = head_q;
  assign fetch_cxt_ingress_data  = head_q[META_WIDTH-1:0];
  assign credit_underflow_err    = err_q;

`ifdef RESP_RECV_ARB_STATS_EN
  logic [31:0] pkt_cnt_q [N_CHAN];
  logic [31:0] stat_sel;
  logic [31:0] stat_q;

  always_comb begin
    stat_sel = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      if (stat_rd_chan == CHAN_LOG'(i)) begin
        stat_sel = pkt_cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else begin
      stat_q <= stat_sel;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        if (cnt_inc[i]) begin
          pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  assign stat_pkt_count = stat_q;
`endif

endmodule

// File: doc/resp_recv_ingress_arbiter.md
Name: resp_recv_ingress_arbiter

Overview:
- Multi-channel front end for the requester response-receive path. Sits between N packet-deparser lanes and the context-fetch ingress of the OoO station.
- Round-robin arbitrates the response packet headers from all lanes and forwards them one at a time, tagged with the lane id.
- Enforces a per-lane cap on outstanding context fetches using credit counters that are released by the downstream stages.

Parameters:
- N_CHAN, 4, number of ingress lanes (2..16).
- CHAN_LOG, 2, lane-id width; equals clog2(N_CHAN).
- META_WIDTH, 256, width of one lane's packet-meta header.
- MAX_OUTSTANDING, 8, maximum in-flight fetches per lane (1..255).
- CNT_WIDTH, 4, credit counter width; equals clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ingress_pkt_valid  in  N_CHAN  per-lane header valid.
- ingress_pkt_head  in  N_CHAN*META_WIDTH  per-lane header; lane i occupies bits [i*META_WIDTH +: META_WIDTH].
- ingress_pkt_ready  out  N_CHAN  per-lane accept.
- fetch_cxt_ingress_valid  out  1  request valid.
- fetch_cxt_ingress_head  out  META_WIDTH+CHAN_LOG  {lane_id, meta}; lane_id in the MSBs.
- fetch_cxt_ingress_data  out  META_WIDTH  copy of meta.
- fetch_cxt_ingress_start  out  1  first beat; equals valid (single-beat requests).
- fetch_cxt_ingress_last  out  1  last beat; equals valid.
- fetch_cxt_ingress_ready  in  1  downstream accept.
- cxt_release_valid  in  1  one fetch of lane cxt_release_chan has retired; no backpressure.
- cxt_release_chan  in  CHAN_LOG  lane being released.
- chan_outstanding  out  N_CHAN*CNT_WIDTH  live credit counters.
- credit_underflow_err  out  1  sticky error flag.

Behaviour:
- Reset (async, active-high): all outputs 0, counters 0, state IDLE, round-robin pointer 0.
- Eligibility: lane i is eligible when ingress_pkt_valid[i] is high and cnt[i] < MAX_OUTSTANDING.
- Grant: the first eligible lane searching upward from rr_ptr+1, with wrap-around at N_CHAN.
- FSM IDLE:
  - If any lane is eligible, drive ingress_pkt_ready[grant]=1 combinationally (one-hot; all other readies 0).
  - Capture head into the output register, increment cnt[grant], set rr_ptr=grant, go to ISSUE.
  - If no lane is eligible, stay in IDLE with all readies 0.
- FSM ISSUE:
  - fetch_cxt_ingress_valid=1; head, data, start and last held stable until accepted.
  - On fetch_cxt_ingress_ready=1, the same cycle re-arbitrates exactly as in IDLE (back-to-back, 1 request/cycle sustained). If a lane is granted, stay in ISSUE with new contents; otherwise go to IDLE.
  - While fetch_cxt_ingress_ready=0, all ingress readies stay 0.
- Latency: 1 cycle from lane accept to fetch_cxt_ingress_valid.
- Credits:
  - cxt_release_valid decrements cnt[cxt_release_chan].
  - Increment and decrement on the same lane in the same cycle leave the count unchanged.
  - A release on a lane whose count is 0 is ignored and sets credit_underflow_err, which stays set until reset.
  - A release whose cxt_release_chan >= N_CHAN is ignored and sets the same flag.
- Full lane: a lane at MAX_OUTSTANDING is skipped and does not block the other lanes. It becomes eligible in the cycle after its count drops.
- Ready never depends on fetch_cxt_ingress_valid of the same cycle except through ISSUE-state acceptance; there are no combinational loops.
- Reset asserted mid-operation discards the held request and clears all counters; downstream is required to be reset together with this block.

Optional Feature:
- Macro: RESP_RECV_ARB_STATS_EN.
- When defined, adds two ports:
  - stat_rd_chan  in  CHAN_LOG  lane select.
  - stat_pkt_count  out  32  registered 1-cycle-latency read of that lane's accepted-packet counter.
- Each lane's 32-bit accepted-packet counter wraps modulo 2^32 and clears on reset.
- When not defined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Single lane: lane 2 presents meta 0xA5 with downstream ready held high -> ingress_pkt_ready[2] pulses for 1 cycle; next cycle fetch_cxt_ingress_valid=1 with head {2'd2, 0xA5} and start=last=1; chan_outstanding lane2=1.
- Fairness: lanes 0-3 all valid continuously, downstream always ready, no releases -> grants cycle 1,2,3,0,1,... one per cycle; after 8 grants per lane all readies go low and every counter equals 8.
- Credit stall: lane 0 at MAX_OUTSTANDING=8 while lane 1 is valid -> lane 1 keeps being served. A release on lane 0 -> lane 0 is granted within 2 cycles of the release.
- Backpressure: fetch_cxt_ingress_ready held low for 5 cycles while request {1, 0x33} is pending -> head stable throughout and no ingress ready asserted; ready=1 -> accepted in that cycle and the next lane granted in the same cycle.
- Simultaneous events and underflow: inc and release on lane 3 in the same cycle -> count unchanged. Release on lane 1 with count 0 -> credit_underflow_err=1, count stays 0.
- Mid-operation reset: rst asserted while in ISSUE -> valid drops immediately and all counters read 0. With RESP_RECV_ARB_STATS_EN defined, stat_pkt_count reads 0 after reset and 3 after 3 lane-0 accepts.
